// File: rtl/pipeline_en_flush_arstn.sv
// Multi-stage valid/ready pipeline register with global enable and
// synchronous flush. Bubbles collapse toward the output, so a stall only
// back-pressures up to the first empty stage. Stage 0 is the input side and
// stage DEPTH-1 is the output side.
module pipeline_en_flush_arstn #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  logic             w_run;
  logic             w_in_fire;
  logic [DEPTH:0]   w_adv;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];

  assign w_run = en & ~flush;

  // Advance chain. adv[i] = ~valid[i] | adv[i+1] unrolled into the
  // equivalent "out_ready, or some stage at or after i is empty" so that no
  // bit of the vector feeds another bit of the same vector.
  always_comb begin
    logic v_full;
    w_adv        = '0;
    w_adv[DEPTH] = out_ready;
    v_full       = 1'b1;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      v_full                 = v_full & r_valid[DEPTH-1-j];
      w_adv[DEPTH-1-j]       = out_ready | ~v_full;
    end
  end

  // Upstream handshake; held low during reset so nothing is taken then.
  assign in_ready  = rstn & w_run & w_adv[0];
  assign w_in_fire = in_valid & in_ready;

  // Source of each stage's next contents: din for stage 0, else the stage before.
  always_comb begin
    w_src_valid    = '0;
    w_src_valid[0] = w_in_fire;
    w_src_data[0]  = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src_data[i]  = r_data[i-1];
    end
  end

  assign w_load = {DEPTH{w_run}} & w_adv[DEPTH-1:0];

  // Downstream side; dout is forced to the reset value while flushing.
  assign out_valid = w_run & r_valid[DEPTH-1];
  assign dout      = flush ? RESET_VAL : r_data[DEPTH-1];

  // Occupancy is a pure function of the stored valid bits.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(r_valid[i]);
    end
  end

  // Stage registers: data only moves when a live payload arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
    end else if (flush) begin
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= RESET_VAL;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_valid[i] <= w_src_valid[i];
          if (w_src_valid[i]) begin
            r_data[i] <= w_src_data[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_en_flush_arstn.sv
// Directed bench with a scoreboard for pipeline_en_flush_arstn (WIDTH=8, DEPTH=3).
module tb_pipeline_en_flush_arstn;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rstn, en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  din, dout;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  pipeline_en_flush_arstn #(
    .WIDTH(W),
    .DEPTH(D),
    .RESET_VAL(8'h00)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .en(en),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .din(din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout(dout),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy);
    in_valid  = iv;
    din       = d;
    out_ready = ordy;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    fork
      // Scoreboard monitor: pop/compare on every downstream transfer,
      // record every upstream transfer.
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: dout=0x%0h emitted, expected no output at %0t", dout, $time);
          end else begin
            chk("sb_dout", dout, exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(din);
      end
    join_none

    // Reset state
    smp();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_count", count, 0);
    nxt();
    rstn = 1'b1;
    nxt();

    // Fill: single payload, latency DEPTH
    drive(1'b1, 8'h11, 1'b1);
    smp(); chk("fill_in_ready", in_ready, 1);
    nxt(); drive(1'b0, 8'h00, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      smp();
      chk("fill_out_valid", out_valid, (c == 3) ? 1 : 0);
      chk("fill_count", count, (c <= 3) ? 1 : 0);
      nxt();
    end

    // Streaming 0x01..0x0A
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, W'(i + 1), 1'b1);
      smp();
      chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, (i >= 3) ? 1 : 0);
      nxt();
    end
    drive(1'b0, 8'h00, 1'b1);
    for (int c = 10; c <= 13; c++) begin
      smp(); chk("stream_drain_valid", out_valid, (c <= 12) ? 1 : 0);
      nxt();
    end

    // Backpressure with bubble collapse: A1, gap, A2, gap, A3
    drive(1'b1, 8'hA1, 1'b0); nxt();
    drive(1'b0, 8'h00, 1'b0); nxt();
    drive(1'b1, 8'hA2, 1'b0); nxt();
    drive(1'b0, 8'h00, 1'b0); nxt();
    drive(1'b1, 8'hA3, 1'b0);
    smp(); chk("bp_count2", count, 2); chk("bp_in_ready_partial", in_ready, 1);
    nxt();
    drive(1'b1, 8'hA4, 1'b0);
    smp(); chk("bp_count_full", count, 3); chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    nxt();
    smp(); chk("bp_hold_count", count, 3); chk("bp_hold_dout", dout, 8'hA1);
    nxt();
    drive(1'b1, 8'hA4, 1'b1);
    smp(); chk("bp_full_pass_in_ready", in_ready, 1);
    nxt();
    drive(1'b0, 8'h00, 1'b1);
    smp(); chk("bp_full_pass_count", count, 3);
    nxt(); nxt(); nxt(); nxt();
    smp(); chk("bp_drained", count, 0);
    nxt();

    // Flush mid-stream
    drive(1'b1, 8'hB1, 1'b0); nxt();
    drive(1'b1, 8'hB2, 1'b0); nxt();
    drive(1'b1, 8'hB3, 1'b0); nxt();
    drive(1'b1, 8'hB4, 1'b1); flush = 1'b1;
    smp();
    chk("fl_in_ready", in_ready, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_dout", dout, 8'h00);
    chk("fl_count_before", count, 3);
    nxt();
    flush = 1'b0; exp_q.delete();
    drive(1'b0, 8'h00, 1'b1);
    smp(); chk("fl_count_after", count, 0); chk("fl_out_valid_after", out_valid, 0);
    nxt(); nxt(); nxt(); nxt();

    // Enable freeze with two entries in stages 2 and 1
    drive(1'b1, 8'hC1, 1'b0); nxt();
    drive(1'b1, 8'hC2, 1'b0); nxt();
    drive(1'b0, 8'h00, 1'b0); nxt();
    en = 1'b0;
    drive(1'b1, 8'hC9, 1'b1);
    for (int c = 0; c < 4; c++) begin
      smp();
      chk("frz_count", count, 2);
      chk("frz_in_ready", in_ready, 0);
      chk("frz_out_valid", out_valid, 0);
      chk("frz_dout", dout, 8'hC1);
      nxt();
    end
    en = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    nxt(); nxt(); nxt();
    smp(); chk("frz_drained", count, 0);
    nxt();

    // Asynchronous reset while full
    drive(1'b1, 8'hD1, 1'b0); nxt();
    drive(1'b1, 8'hD2, 1'b0); nxt();
    drive(1'b1, 8'hD3, 1'b0); nxt();
    drive(1'b0, 8'h00, 1'b1);
    smp(); chk("ar_full", count, 3);
    #2 rstn = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_dout", dout, 8'h00);
    chk("ar_in_ready", in_ready, 0);
    exp_q.delete();
    nxt();
    rstn = 1'b1;
    nxt();
    drive(1'b1, 8'hE1, 1'b1);
    smp(); chk("ar_push_ready", in_ready, 1);
    nxt(); drive(1'b0, 8'h00, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      smp(); chk("ar_latency", out_valid, (c == 3) ? 1 : 0);
      nxt();
    end
    nxt(); nxt();

    chk("sb_empty_at_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
